// File: rtl/alu_dec_cluster_if.sv
// ---------------------------------------------------------------------------
// alu_dec_cluster_if
// Groups the switch-side inputs and LED/display-side outputs of
// alu_dec_cluster. Clock and reset are kept off this bundle.
//
// Signals:
//   alu_fnselec[2:0]  ALU function select            (master -> slave)
//   alu_a[3:0]        ALU operand A, two's complement (master -> slave)
//   alu_b[3:0]        ALU operand B, two's complement (master -> slave)
//   x[2:0]            decoder select                 (master -> slave)
//   en                decoder enable                 (master -> slave)
//   counter_en        down-counter count enable      (master -> slave)
//   alu_res[3:0]      ALU result                     (slave -> master)
//   alu_zero          result is zero                 (slave -> master)
//   alu_overflow      signed overflow (add/sub only) (slave -> master)
//   alu_carry         carry-out (add/sub only)       (slave -> master)
//   y_dec[7:0]        one-hot decoder output         (slave -> master)
//   dec_counter_out   down-counter value             (slave -> master)
//
// There is no valid/ready handshake: every input is level-sensitive and
// every output is either combinational or the registered counter value.
// ---------------------------------------------------------------------------
interface alu_dec_cluster_if;
    logic [2:0] alu_fnselec;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] x;
    logic       en;
    logic       counter_en;
    logic [3:0] alu_res;
    logic       alu_zero;
    logic       alu_overflow;
    logic       alu_carry;
    logic [7:0] y_dec;
    logic [2:0] dec_counter_out;

    modport master (
        output alu_fnselec, alu_a, alu_b, x, en, counter_en,
        input  alu_res, alu_zero, alu_overflow, alu_carry, y_dec,
               dec_counter_out
    );

    modport slave (
        input  alu_fnselec, alu_a, alu_b, x, en, counter_en,
        output alu_res, alu_zero, alu_overflow, alu_carry, y_dec,
               dec_counter_out
    );
endinterface

// File: rtl/alu_dec_cluster.sv
// ---------------------------------------------------------------------------
// alu_dec_cluster
// Lab datapath cluster: a 4-bit two's-complement ALU with flags, a 3-to-8
// one-hot decoder with enable, and a 3-bit enabled down-counter.
//
// Ports:
//   clk     rising-edge clock for the counter
//   resetn  synchronous active-low reset (counter loads 3'b111)
//   bus     alu_dec_cluster_if.slave - ALU/decoder/counter inputs and outputs
//
// The ALU and decoder are purely combinational and ignore reset.
// ---------------------------------------------------------------------------
module alu_dec_cluster (
    input  logic                     clk,
    input  logic                     resetn,
    alu_dec_cluster_if.slave         bus
);

    // ALU function codes
    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_NOT = 3'b010;
    localparam logic [2:0] FN_AND = 3'b011;
    localparam logic [2:0] FN_OR  = 3'b100;
    localparam logic [2:0] FN_XOR = 3'b101;
    localparam logic [2:0] FN_SLT = 3'b110;
    localparam logic [2:0] FN_EQ  = 3'b111;

    // -----------------------------------------------------------------------
    // ALU
    // -----------------------------------------------------------------------
    logic [4:0] w_add_sum;
    logic [4:0] w_sub_sum;
    logic       w_add_ovf;
    logic       w_sub_ovf;
    logic       w_slt;
    logic [3:0] w_res;
    logic       w_carry;
    logic       w_ovf;

    assign w_add_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    // Subtraction as A + ~B + 1; bit 4 is the "no borrow" carry.
    assign w_sub_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 5'd1;

    assign w_add_ovf = (bus.alu_a[3] == bus.alu_b[3]) &&
                       (w_add_sum[3] != bus.alu_a[3]);
    assign w_sub_ovf = (bus.alu_a[3] != bus.alu_b[3]) &&
                       (w_sub_sum[3] != bus.alu_a[3]);

    // Signed A < B: sign of the difference, corrected when it overflowed.
    assign w_slt = w_sub_sum[3] ^ w_sub_ovf;

    always_comb begin
        w_res   = 4'b0000;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (bus.alu_fnselec)
            FN_ADD: begin
                w_res   = w_add_sum[3:0];
                w_carry = w_add_sum[4];
                w_ovf   = w_add_ovf;
            end
            FN_SUB: begin
                w_res   = w_sub_sum[3:0];
                w_carry = w_sub_sum[4];
                w_ovf   = w_sub_ovf;
            end
            FN_NOT: w_res = ~bus.alu_a;
            FN_AND: w_res = bus.alu_a & bus.alu_b;
            FN_OR:  w_res = bus.alu_a | bus.alu_b;
            FN_XOR: w_res = bus.alu_a ^ bus.alu_b;
            FN_SLT: w_res = {3'b000, w_slt};
            FN_EQ:  w_res = {3'b000, (bus.alu_a == bus.alu_b)};
            default: w_res = 4'b0000;
        endcase
    end

    assign bus.alu_res      = w_res;
    assign bus.alu_zero     = (w_res == 4'b0000);
    assign bus.alu_carry    = w_carry;
    assign bus.alu_overflow = w_ovf;

    // -----------------------------------------------------------------------
    // 3-to-8 decoder
    // -----------------------------------------------------------------------
    logic [7:0] w_y_dec;

    always_comb begin
        w_y_dec = 8'h00;
        if (bus.en) begin
            w_y_dec[bus.x] = 1'b1;
        end
    end

    assign bus.y_dec = w_y_dec;

    // -----------------------------------------------------------------------
    // Down-counter: reset loads 111, count wraps 000 -> 111 naturally.
    // -----------------------------------------------------------------------
    logic [2:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= 3'b111;
        end else if (bus.counter_en) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign bus.dec_counter_out = r_cnt;

endmodule

// File: tb/tb_alu_dec_cluster.sv
// ---------------------------------------------------------------------------
// tb_alu_dec_cluster
// Self-checking bench for alu_dec_cluster: hand-computed literal cases plus
// random stimulus compared every cycle against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_dec_cluster;

  logic clk;
  logic resetn;
  alu_dec_cluster_if bus ();

  alu_dec_cluster dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  // ---------------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // reference model
  // ---------------------------------------------------------------------
  function automatic void alu_model(input logic [2:0] fn, input logic [3:0] a,
                                    input logic [3:0] b, output logic [3:0] res,
                                    output logic z, output logic ov, output logic cy);
    int ua;
    int ub;
    int sa;
    int sb;
    int r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    ov = 1'b0;
    cy = 1'b0;
    r  = 0;
    case (fn)
      3'd0: begin r = ua + ub; cy = (r > 15); ov = (sa + sb > 7) || (sa + sb < -8); end
      3'd1: begin r = ua - ub; cy = (ua >= ub); ov = (sa - sb > 7) || (sa - sb < -8); end
      3'd2: r = 15 - ua;
      3'd3: r = ua & ub;
      3'd4: r = ua | ub;
      3'd5: r = ua ^ ub;
      3'd6: r = (sa < sb) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    res = r[3:0];
    z   = (res == 4'd0);
  endfunction

  function automatic logic [7:0] dec_model(input logic [2:0] xs, input logic e);
    int v;
    v = e ? (2 ** int'(xs)) : 0;
    return v[7:0];
  endfunction

  // counter model: value known once a reset edge has been seen
  int m_cnt   = 0;
  bit m_valid = 1'b0;
  always @(posedge clk) begin
    if (!resetn) begin
      m_cnt   = 7;
      m_valid = 1'b1;
    end else if (bus.counter_en && m_valid) begin
      m_cnt = (m_cnt == 0) ? 7 : m_cnt - 1;
    end
  end

  // ---------------------------------------------------------------------
  // scoreboard helpers
  // ---------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // compare process: every negedge, all outputs against the model
  always @(negedge clk) begin
    logic [3:0] e_res;
    logic       e_z;
    logic       e_ov;
    logic       e_cy;
    alu_model(bus.alu_fnselec, bus.alu_a, bus.alu_b, e_res, e_z, e_ov, e_cy);
    chk("model_res",   int'(bus.alu_res),      int'(e_res));
    chk("model_zero",  int'(bus.alu_zero),     int'(e_z));
    chk("model_ovf",   int'(bus.alu_overflow), int'(e_ov));
    chk("model_carry", int'(bus.alu_carry),    int'(e_cy));
    chk("model_ydec",  int'(bus.y_dec),        int'(dec_model(bus.x, bus.en)));
    if (m_valid) chk("model_cnt", int'(bus.dec_counter_out), m_cnt);
  end

  // ---------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------
  task automatic alu_lit(input string name, input logic [2:0] fn, input logic [3:0] a,
                         input logic [3:0] b, input int res, input int z,
                         input int ov, input int cy);
    @(posedge clk);
    #1;
    bus.alu_fnselec = fn;
    bus.alu_a       = a;
    bus.alu_b       = b;
    #1;
    chk({name, "_res"},   int'(bus.alu_res),      res);
    chk({name, "_zero"},  int'(bus.alu_zero),     z);
    chk({name, "_ovf"},   int'(bus.alu_overflow), ov);
    chk({name, "_carry"}, int'(bus.alu_carry),    cy);
  endtask

  task automatic dec_lit(input logic [2:0] xs, input logic e, input int expv);
    @(posedge clk);
    #1;
    bus.x  = xs;
    bus.en = e;
    #1;
    chk("dec_lit", int'(bus.y_dec), expv);
  endtask

  // ---------------------------------------------------------------------
  // main sequence
  // ---------------------------------------------------------------------
  initial begin
    resetn          = 1'b0;
    bus.counter_en  = 1'b0;
    bus.alu_fnselec = 3'd0;
    bus.alu_a       = 4'd0;
    bus.alu_b       = 4'd0;
    bus.x           = 3'd0;
    bus.en          = 1'b0;

    // reset held for two edges
    repeat (2) @(posedge clk);
    #2;
    chk("reset_cnt", int'(bus.dec_counter_out), 7);

    // ALU literal cases: name, fn, a, b, res, zero, ovf, carry
    alu_lit("add_ovf",  3'b000, 4'b0111, 4'b0001, 4'b1000, 0, 1, 0);
    alu_lit("add_wrap", 3'b000, 4'b1111, 4'b0001, 4'b0000, 1, 0, 1);
    alu_lit("sub_neg",  3'b001, 4'b0011, 4'b0101, 4'b1110, 0, 0, 0);
    alu_lit("slt_3_5",  3'b110, 4'b0011, 4'b0101, 4'b0001, 0, 0, 0);
    alu_lit("sub_ovf",  3'b001, 4'b1000, 4'b0111, 4'b0001, 0, 1, 1);
    alu_lit("slt_ovf",  3'b110, 4'b1000, 4'b0111, 4'b0001, 0, 0, 0);
    alu_lit("eq_true",  3'b111, 4'b1010, 4'b1010, 4'b0001, 0, 0, 0);
    alu_lit("eq_false", 3'b111, 4'b1010, 4'b0101, 4'b0000, 1, 0, 0);
    alu_lit("not",      3'b010, 4'b1100, 4'b1010, 4'b0011, 0, 0, 0);
    alu_lit("and",      3'b011, 4'b1100, 4'b1010, 4'b1000, 0, 0, 0);
    alu_lit("or",       3'b100, 4'b1100, 4'b1010, 4'b1110, 0, 0, 0);
    alu_lit("xor",      3'b101, 4'b1100, 4'b1010, 4'b0110, 0, 0, 0);

    // decoder sweep
    begin
      int onehot;
      onehot = 1;
      for (int i = 0; i < 8; i++) begin
        dec_lit(3'(i), 1'b1, onehot);
        onehot = onehot * 2;
      end
      for (int i = 0; i < 8; i++) dec_lit(3'(i), 1'b0, 0);
    end

    // counter: release reset with count enabled, 9 edges including wrap
    @(posedge clk);
    #1;
    resetn         = 1'b1;
    bus.counter_en = 1'b1;
    begin
      int seq[9] = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
      foreach (seq[i]) exp_q.push_back(3'(seq[i]));
    end
    repeat (9) begin
      @(posedge clk);
      #2;
      chk("cnt_run", int'(bus.dec_counter_out), int'(exp_q.pop_front()));
    end

    // hold for 3 edges
    bus.counter_en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("cnt_hold", int'(bus.dec_counter_out), 6);
    end

    // one more decrement, then reset mid-count
    bus.counter_en = 1'b1;
    @(posedge clk);
    #2;
    chk("cnt_step", int'(bus.dec_counter_out), 5);
    resetn = 1'b0;
    @(posedge clk);
    #2;
    chk("cnt_midrst", int'(bus.dec_counter_out), 7);

    // random stimulus, checked by the compare process each negedge
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      resetn          = ($urandom_range(0, 9) != 0);
      bus.counter_en  = ($urandom_range(0, 3) != 0);
      bus.alu_fnselec = 3'($urandom_range(0, 7));
      bus.alu_a       = 4'($urandom_range(0, 15));
      bus.alu_b       = ($urandom_range(0, 4) == 0) ? bus.alu_a : 4'($urandom_range(0, 15));
      bus.x           = 3'($urandom_range(0, 7));
      bus.en          = 1'($urandom_range(0, 1));
    end

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
